galaxian_loader: RTL
====================

# galaxian_loader

Download-side front end for the Galaxian-family core. It sits between hps_io's ioctl stream and the galaxian core. It routes ROM bytes (index 0) onto the core's dn_* write port, latches the game-select byte (index 1) into a one-hot mod vector, and captures DIP bytes (index 254). It also sequences core reset so the core only runs after a complete ROM load plus a settle delay.

## Interface
- ROM_BYTES, default 65536: accepted ROM window; bytes with ioctl_addr >= ROM_BYTES are dropped.
- HOLD_CYCLES, default 16: clk_sys cycles of core reset held after the ROM download ends (1..255).
- MOD_COUNT, default 17: number of valid game IDs; width of mod_sel.
- clk_sys  in  1  system clock (12 MHz).
- reset_n  in  1  synchronous, active-low reset.
- ioctl_download  in  1  download in progress.
- ioctl_wr  in  1  byte strobe, one cycle.
- ioctl_addr  in  25  byte address.
- ioctl_dout  in  8  byte data.
- ioctl_index  in  8  stream index: 0 ROM, 1 mod, 254 DIP.
- dn_addr  out  16  ROM write address to the core.
- dn_data  out  8  ROM write data.
- dn_wr  out  1  ROM write strobe, one cycle.
- mod_sel  out  MOD_COUNT  one-hot game select.
- sw0, sw1, sw2  out  8 each  DIP bytes 0..2.
- core_reset  out  1  active-high reset to the core.
- load_done  out  1  high while state is RUN.
- rom_overflow  out  1  sticky; a ROM byte fell outside the window.
- rom_csum  out  16  additive checksum of forwarded ROM bytes.

## Operation
- States are IDLE, LOAD, HOLD and RUN.
- Reset puts the block in IDLE. Reset values:
  - dn_wr=0, dn_addr=0, dn_data=0.
  - mod register = 0, so mod_sel = 1 (galaxian).
  - sw0/1/2 = 0x00.
  - core_reset = 1, load_done = 0, rom_overflow = 0, rom_csum = 0.
- IDLE → LOAD when ioctl_download=1 and ioctl_index=0.
- LOAD:
  - each ioctl_wr with addr < ROM_BYTES is forwarded to dn_addr/dn_data and pulses dn_wr.
  - each ioctl_wr with addr ≥ ROM_BYTES is dropped and sets rom_overflow.
  - LOAD → HOLD when ioctl_download=0. The hold counter loads HOLD_CYCLES-1.
- HOLD: the counter decrements each cycle. At 0 the state moves to RUN.
- RUN: core_reset=0 and load_done=1.
- A new index-0 download in HOLD or RUN returns to LOAD. Entering LOAD clears rom_csum and rom_overflow.
- core_reset=1 in IDLE, LOAD and HOLD.
- Index 1 writes are accepted in any state. The last byte written is latched as the mod value.
  - mod_sel[mod] = 1 when mod < MOD_COUNT.
  - Any value ≥ MOD_COUNT decodes to bit 0.
- Index 254 writes are accepted in any state when addr[24:3]==0: sw[addr[2:0]] ← data. Only entries 0..2 are output.
- Index-1 and index-254 downloads do not change the state.

## Timing
- dn_addr, dn_data and dn_wr are registered: dn_wr rises one cycle after the qualifying ioctl_wr and is high for exactly one cycle.
- mod_sel updates two cycles after the ioctl_wr: one cycle to latch, one to decode.
- sw* update one cycle after the ioctl_wr.
- ioctl_wr in the same cycle that ioctl_download falls is still forwarded. The LOAD→HOLD transition happens in that same edge.
- core_reset falls exactly HOLD_CYCLES cycles after the first cycle with ioctl_download=0.
- reset_n low mid-LOAD: the next edge gives IDLE with all outputs at their reset values. No dn_wr is issued for a strobe coincident with reset.
- The core must see core_reset=1 on every cycle on which dn_wr=1.

## Configuration
- GALAXIAN_LOADER_CSUM_EN defined:
  - rom_csum accumulates each forwarded byte modulo 2^16, updated with dn_wr.
  - Dropped bytes are not counted.
- GALAXIAN_LOADER_CSUM_EN undefined: rom_csum is tied to 0 and the accumulator is not built.

## Structure
- galaxian_pkg holds:
  - the loader_state_t enum (IDLE, LOAD, HOLD, RUN).
  - the index constants IDX_ROM=0, IDX_MOD=1, IDX_DIP=254.
  - the game ID constants MOD_GALAXIAN=0 … MOD_TRIPLEDR=16.
- One sub-module, galaxian_mod_decode: registered binary-to-one-hot decoder with out-of-range fallback to bit 0.

## Test plan
- Full ROM load:
  - stimulus: index 0, bytes 0x00..0xFF at addr 0..255, then download falls.
  - required: 256 dn_wr pulses, each one cycle after its strobe.
  - required: core_reset falls 16 cycles after download end.
  - required: rom_csum = 0x7F80 when the macro is defined.
- Overflow:
  - stimulus: with ROM_BYTES=4096, write addr 0x0FFF then 0x1000.
  - required: one dn_wr (addr 0x0FFF); rom_overflow=1; core still reaches RUN.
- Mod select:
  - stimulus: index 1 byte 0x0A.
  - required: mod_sel = 17'h00400 two cycles later.
  - stimulus: byte 0x20.
  - required: mod_sel = 17'h00001.
- DIP capture:
  - stimulus: index 254, addr 2 = 0xA5, then addr 8 = 0x11.
  - required: sw2 = 0xA5; addr 8 ignored; sw0 = sw1 = 0x00.
- Reload from RUN:
  - stimulus: start a second index-0 download.
  - required: core_reset=1 on the next edge; rom_csum and rom_overflow cleared.
- Reset mid-LOAD:
  - stimulus: reset_n=0 coincident with ioctl_wr.
  - required: no dn_wr; state IDLE; mod_sel=1; sw* = 0; core_reset=1.

Source files
------------

// File: rtl/galaxian_pkg.sv
// Shared types and constants for the Galaxian-family download front end:
// loader states, hps_io stream indices and game IDs.
package galaxian_pkg;

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        HOLD,
        RUN
    } loader_state_t;

    localparam logic [7:0] IDX_ROM = 8'd0;
    localparam logic [7:0] IDX_MOD = 8'd1;
    localparam logic [7:0] IDX_DIP = 8'd254;

    // Game IDs as sent by the OSD in the index-1 stream
    localparam logic [7:0] MOD_GALAXIAN  = 8'd0;
    localparam logic [7:0] MOD_MOONCRST  = 8'd1;
    localparam logic [7:0] MOD_MOONQSR   = 8'd2;
    localparam logic [7:0] MOD_KINGBAL   = 8'd3;
    localparam logic [7:0] MOD_OMEGA     = 8'd4;
    localparam logic [7:0] MOD_PISCES    = 8'd5;
    localparam logic [7:0] MOD_UNIWARS   = 8'd6;
    localparam logic [7:0] MOD_DEVILFSH  = 8'd7;
    localparam logic [7:0] MOD_BLACKHOLE = 8'd8;
    localparam logic [7:0] MOD_CATACOMB  = 8'd9;
    localparam logic [7:0] MOD_ZIGZAG    = 8'd10;
    localparam logic [7:0] MOD_WAROFBUG  = 8'd11;
    localparam logic [7:0] MOD_ORBITRON  = 8'd12;
    localparam logic [7:0] MOD_AZURIAN   = 8'd13;
    localparam logic [7:0] MOD_MRDONM    = 8'd14;
    localparam logic [7:0] MOD_VICTORY   = 8'd15;
    localparam logic [7:0] MOD_TRIPLEDR  = 8'd16;

endpackage

// File: rtl/galaxian_loader_if.sv
// hps_io ioctl download stream as seen by the loader; master is the hps_io
// side, slave is the loader.
interface galaxian_loader_if;

    logic        ioctl_download;
    logic        ioctl_wr;
    logic [24:0] ioctl_addr;
    logic [7:0]  ioctl_dout;
    logic [7:0]  ioctl_index;

    modport master (
        output ioctl_download,
        output ioctl_wr,
        output ioctl_addr,
        output ioctl_dout,
        output ioctl_index
    );

    modport slave (
        input ioctl_download,
        input ioctl_wr,
        input ioctl_addr,
        input ioctl_dout,
        input ioctl_index
    );

endinterface

// File: rtl/galaxian_mod_decode.sv
// Registered binary-to-one-hot game select; IDs outside 0..MOD_COUNT-1 fall
// back to bit 0 so the core always has exactly one game selected.
module galaxian_mod_decode #(
    parameter int MOD_COUNT = 17
) (
    input  logic                 clk_sys,
    input  logic                 reset_n,
    input  logic [7:0]           mod_val,
    output logic [MOD_COUNT-1:0] mod_sel
);

    localparam logic [8:0] MOD_LIMIT = 9'(MOD_COUNT);

    logic [MOD_COUNT-1:0] onehot;

    always_comb begin
        onehot = '0;
        for (int i = 0; i < MOD_COUNT; i++) begin
            if (mod_val == 8'(i)) begin
                onehot[i] = 1'b1;
            end
        end
        if ({1'b0, mod_val} >= MOD_LIMIT) begin
            onehot[0] = 1'b1;
        end
    end

    always_ff @(posedge clk_sys) begin
        if (!reset_n) begin
            mod_sel <= MOD_COUNT'(1);
        end else begin
            mod_sel <= onehot;
        end
    end

endmodule

// File: rtl/galaxian_loader.sv
// Download front end for the Galaxian core: routes ROM/mod/DIP streams and
// holds core reset until a full ROM load has settled. Optional checksum is
// built when GALAXIAN_LOADER_CSUM_EN is defined.
module galaxian_loader
    import galaxian_pkg::*;
#(
    parameter int ROM_BYTES   = 65536,
    parameter int HOLD_CYCLES = 16,
    parameter int MOD_COUNT   = 17
) (
    input  logic                 clk_sys,
    input  logic                 reset_n,
    galaxian_loader_if.slave     ioctl,
    output logic [15:0]          dn_addr,
    output logic [7:0]           dn_data,
    output logic                 dn_wr,
    output logic [MOD_COUNT-1:0] mod_sel,
    output logic [7:0]           sw0,
    output logic [7:0]           sw1,
    output logic [7:0]           sw2,
    output logic                 core_reset,
    output logic                 load_done,
    output logic                 rom_overflow,
    output logic [15:0]          rom_csum
);

    localparam logic [24:0] ROM_LIMIT = 25'(ROM_BYTES);
    localparam logic [7:0]  HOLD_LOAD = 8'(HOLD_CYCLES - 1);

    loader_state_t state, state_next;
    logic [7:0]    hold_cnt, hold_next;
    logic [7:0]    mod_reg;
    logic          rom_start;
    logic          rom_wr;
    logic          fwd_wr;
    logic          drop_wr;
    logic          load_enter;
    logic          dip_wr;

    assign rom_start = ioctl.ioctl_download && (ioctl.ioctl_index == IDX_ROM);
    assign rom_wr    = (state == LOAD) && ioctl.ioctl_wr && (ioctl.ioctl_index == IDX_ROM);
    assign fwd_wr    = rom_wr && (ioctl.ioctl_addr < ROM_LIMIT);
    assign drop_wr   = rom_wr && !(ioctl.ioctl_addr < ROM_LIMIT);
    assign dip_wr    = ioctl.ioctl_wr && (ioctl.ioctl_index == IDX_DIP)
                       && (ioctl.ioctl_addr[24:3] == 22'd0);

    always_comb begin
        state_next = state;
        hold_next  = hold_cnt;
        unique case (state)
            IDLE: begin
                if (rom_start) state_next = LOAD;
            end
            LOAD: begin
                if (!ioctl.ioctl_download) begin
                    state_next = HOLD;
                    hold_next  = HOLD_LOAD;
                end
            end
            HOLD: begin
                if (rom_start) begin
                    state_next = LOAD;
                end else if (hold_cnt == 8'd0) begin
                    state_next = RUN;
                end else begin
                    hold_next = hold_cnt - 8'd1;
                end
            end
            RUN: begin
                if (rom_start) state_next = LOAD;
            end
        endcase
        load_enter = (state_next == LOAD) && (state != LOAD);
        core_reset = (state != RUN);
        load_done  = (state == RUN);
    end

    always_ff @(posedge clk_sys) begin
        if (!reset_n) begin
            state    <= IDLE;
            hold_cnt <= 8'd0;
        end else begin
            state    <= state_next;
            hold_cnt <= hold_next;
        end
    end

    // ROM write port is registered so dn_wr is a clean one-cycle pulse
    always_ff @(posedge clk_sys) begin
        if (!reset_n) begin
            dn_wr        <= 1'b0;
            dn_addr      <= 16'd0;
            dn_data      <= 8'd0;
            rom_overflow <= 1'b0;
        end else begin
            dn_wr <= fwd_wr;
            if (fwd_wr) begin
                dn_addr <= ioctl.ioctl_addr[15:0];
                dn_data <= ioctl.ioctl_dout;
            end
            if (load_enter) begin
                rom_overflow <= 1'b0;
            end else if (drop_wr) begin
                rom_overflow <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk_sys) begin
        if (!reset_n) begin
            mod_reg <= 8'd0;
            sw0     <= 8'd0;
            sw1     <= 8'd0;
            sw2     <= 8'd0;
        end else begin
            if (ioctl.ioctl_wr && (ioctl.ioctl_index == IDX_MOD)) begin
                mod_reg <= ioctl.ioctl_dout;
            end
            if (dip_wr) begin
                case (ioctl.ioctl_addr[2:0])
                    3'd0:    sw0 <= ioctl.ioctl_dout;
                    3'd1:    sw1 <= ioctl.ioctl_dout;
                    3'd2:    sw2 <= ioctl.ioctl_dout;
                    default: ;
                endcase
            end
        end
    end

    galaxian_mod_decode #(
        .MOD_COUNT (MOD_COUNT)
    ) u_mod_decode (
        .clk_sys (clk_sys),
        .reset_n (reset_n),
        .mod_val (mod_reg),
        .mod_sel (mod_sel)
    );

`ifdef GALAXIAN_LOADER_CSUM_EN
    logic [15:0] csum_q;

    // Updated on the same edge that raises dn_wr, so it tracks forwarded bytes only
    always_ff @(posedge clk_sys) begin
        if (!reset_n) begin
            csum_q <= 16'd0;
        end else if (load_enter) begin
            csum_q <= 16'd0;
        end else if (fwd_wr) begin
            csum_q <= csum_q + {8'd0, ioctl.ioctl_dout};
        end
    end

    assign rom_csum = csum_q;
`else
    assign rom_csum = 16'd0;
`endif

endmodule
